io_bus_arbiter: RTL



---
 rtl/io_arb_pkg.sv | 23 ++
 rtl/io_bus_arbiter_rr_grant.sv | 75 +++++++
 rtl/io_bus_arbiter.sv | 140 ++++++++++++++
 3 files changed

// File: rtl/io_arb_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : io_arb_pkg
//  Description : Shared types and constants for the io_bus arbiter. Defines the
//                master id type, which is sized for the largest supported
//                master count, and the round-robin pointer advance helper.
//  Revision    : 1.0 - initial release
// ============================================================================
package io_arb_pkg;

    localparam int IO_ARB_MAX_MASTERS = 8;
    localparam int IO_ARB_ID_WIDTH    = $clog2(IO_ARB_MAX_MASTERS);

    typedef logic [IO_ARB_ID_WIDTH-1:0] master_id_t;

    // Pointer moves to the master just after the granted one. The wrap is an
    // explicit compare so that non-power-of-two master counts work.
    function automatic master_id_t next_ptr(input master_id_t id, input int n);
        return (int'(id) == n - 1) ? '0 : master_id_t'(id + master_id_t'(1));
    endfunction

endpackage
`default_nettype wire

// File: rtl/io_bus_arbiter_rr_grant.sv
`default_nettype none
// ============================================================================
//  Module      : rr_grant
//  Description : Combinational round-robin grant. The request vector is rotated
//                so that the master at rr_ptr sits at position 0. The lowest set
//                bit is then picked, and the result is rotated back.
//  Ports       : req         - per-master request vector
//                rr_ptr      - master with highest priority this cycle
//                grant       - one-hot grant, zero when nothing is requesting
//                grant_id    - encoded id of the granted master
//                grant_valid - a grant was issued
//  Revision    : 1.0 - initial release
// ============================================================================
module rr_grant
    import io_arb_pkg::*;
#(
    parameter int NUM_MASTERS = 2
) (
    input  logic [NUM_MASTERS-1:0] req,
    input  master_id_t             rr_ptr,
    output logic [NUM_MASTERS-1:0] grant,
    output master_id_t             grant_id,
    output logic                   grant_valid
);

    logic [NUM_MASTERS-1:0] w_rot;
    logic                   w_found;
    int                     w_off;
    int                     w_sum;

    always_comb begin
        w_rot       = '0;
        w_found     = 1'b0;
        w_off       = 0;
        w_sum       = 0;
        grant       = '0;
        grant_id    = '0;
        grant_valid = 1'b0;

        // Rotate. Both loop bounds are constant, so every bit index stays static.
        // rr_ptr < NUM_MASTERS, so one conditional subtract is enough to wrap.
        for (int i = 0; i < NUM_MASTERS; i++) begin
            for (int j = 0; j < NUM_MASTERS; j++) begin
                if (((int'(rr_ptr) + i >= NUM_MASTERS) ? int'(rr_ptr) + i - NUM_MASTERS
                                                       : int'(rr_ptr) + i) == j) begin
                    w_rot[i] = req[j];
                end
            end
        end

        // Priority-encode the rotated vector.
        for (int i = 0; i < NUM_MASTERS; i++) begin
            if (!w_found && w_rot[i]) begin
                w_found = 1'b1;
                w_off   = i;
            end
        end

        // Un-rotate back to an absolute master index.
        w_sum = int'(rr_ptr) + w_off;
        if (w_sum >= NUM_MASTERS) begin
            w_sum = w_sum - NUM_MASTERS;
        end

        grant_valid = w_found;
        if (w_found) begin
            grant_id = master_id_t'(w_sum);
            for (int j = 0; j < NUM_MASTERS; j++) begin
                grant[j] = (w_sum == j);
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/io_bus_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : io_bus_arbiter
//  Description : Round-robin arbiter that shares the single io_bus port between
//                NUM_MASTERS requesters. It accepts one transaction per cycle,
//                and grants combinationally in the same cycle. Read data comes
//                back exactly one cycle after the grant and is steered to the
//                master that issued the read.
//  Ports       : clk, reset          - clock, asynchronous active-high reset
//                m_read_en/m_write_en - per-master requests
//                m_address/m_write_data - per-master request payload
//                m_ready             - one-hot acceptance, same cycle
//                m_read_valid        - one-hot read-return strobe
//                m_read_data         - shared read return data
//                s_*                 - io_bus side
//                perf_wait_cycles    - per-master stall counters, only present
//                                      when IO_ARB_PERF_EN is defined
//  Options     : IO_ARB_PERF_EN - adds the saturating wait-cycle counters
//  Revision    : 1.0 - initial release
// ============================================================================
module io_bus_arbiter
    import io_arb_pkg::*;
#(
    parameter int NUM_MASTERS = 2,
    parameter int ADDR_WIDTH  = 32,
    parameter int DATA_WIDTH  = 32
) (
    input  logic                                    clk,
    input  logic                                    reset,
    input  logic [NUM_MASTERS-1:0]                  m_read_en,
    input  logic [NUM_MASTERS-1:0]                  m_write_en,
    input  logic [NUM_MASTERS-1:0][ADDR_WIDTH-1:0]  m_address,
    input  logic [NUM_MASTERS-1:0][DATA_WIDTH-1:0]  m_write_data,
    output logic [NUM_MASTERS-1:0]                  m_ready,
    output logic [NUM_MASTERS-1:0]                  m_read_valid,
    output logic [DATA_WIDTH-1:0]                   m_read_data,
    output logic                                    s_read_en,
    output logic                                    s_write_en,
    output logic [ADDR_WIDTH-1:0]                   s_address,
    output logic [DATA_WIDTH-1:0]                   s_write_data,
    input  logic [DATA_WIDTH-1:0]                   s_read_data
`ifdef IO_ARB_PERF_EN
    ,
    output logic [NUM_MASTERS-1:0][31:0]            perf_wait_cycles
`endif
);

    logic [NUM_MASTERS-1:0] w_req;
    logic [NUM_MASTERS-1:0] w_grant;
    master_id_t             w_grant_id;
    logic                   w_grant_valid;

    master_id_t             r_rr_ptr;
    logic                   r_resp_pending;
    master_id_t             r_resp_id;

    // No grants while reset is held, so every output reads zero during reset.
    assign w_req = (m_read_en | m_write_en) & {NUM_MASTERS{~reset}};

    rr_grant #(
        .NUM_MASTERS (NUM_MASTERS)
    ) u_rr_grant (
        .req         (w_req),
        .rr_ptr      (r_rr_ptr),
        .grant       (w_grant),
        .grant_id    (w_grant_id),
        .grant_valid (w_grant_valid)
    );

    // Mux the granted master onto io_bus with AND-OR on the one-hot grant.
    // A read paired with a write from the same master is dropped, and the
    // write wins.
    always_comb begin
        m_ready      = w_grant;
        s_read_en    = |(w_grant & m_read_en & ~m_write_en);
        s_write_en   = |(w_grant & m_write_en);
        s_address    = '0;
        s_write_data = '0;
        for (int i = 0; i < NUM_MASTERS; i++) begin
            if (w_grant[i]) begin
                s_address    = m_address[i];
                s_write_data = m_write_data[i];
            end
        end
    end

    // Read return: io_bus data is already one cycle behind read_en, so it is
    // passed straight through. It is qualified by the registered pending flag.
    always_comb begin
        m_read_valid = '0;
        for (int i = 0; i < NUM_MASTERS; i++) begin
            m_read_valid[i] = r_resp_pending && (r_resp_id == master_id_t'(i));
        end
        m_read_data = r_resp_pending ? s_read_data : '0;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_rr_ptr       <= '0;
            r_resp_pending <= 1'b0;
            r_resp_id      <= '0;
        end else begin
            if (w_grant_valid) begin
                r_rr_ptr <= next_ptr(w_grant_id, NUM_MASTERS);
            end
            // One-deep pipeline. A new read may replace the previous one every
            // cycle, because the previous response is consumed in that cycle.
            r_resp_pending <= s_read_en;
            if (s_read_en) begin
                r_resp_id <= w_grant_id;
            end
        end
    end

`ifdef IO_ARB_PERF_EN
    logic [NUM_MASTERS-1:0][31:0] r_perf_wait;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_perf_wait <= '0;
        end else begin
            for (int i = 0; i < NUM_MASTERS; i++) begin
                if (w_req[i] && !w_grant[i] && (r_perf_wait[i] != 32'hffff_ffff)) begin
                    r_perf_wait[i] <= r_perf_wait[i] + 32'd1;
                end
            end
        end
    end

    assign perf_wait_cycles = r_perf_wait;
`endif

`ifndef SYNTHESIS
    // Flags a master that raises read and write in the same cycle.
    a_rw_exclusive : assert property (@(posedge clk) disable iff (reset)
                                      !(|(m_read_en & m_write_en)));
`endif

endmodule
`default_nettype wire
